data_mem_responder: RTL and testbench

Word-organised data memory that answers the core's load/store port as the responder end of a valid/ready request/response interface. It accepts one request at a time and inserts a programmable number of wait cycles. It performs byte-masked writes and full-word reads, then returns a response that is held until the core consumes it. It sits beside the microprocessor top level and gives the load/store unit a realistic, stallable memory target.

---
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory. It is the responder end of a valid/ready
//   load/store port. It takes one request at a time and adds Latency wait
//   cycles before the access. Stores are byte-masked and loads read a full
//   word. The response is held until the core accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_wmask  byte-lane write enables
//   rsp_valid  response present
//   rsp_ready  core accepts response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    request was misaligned or out of range
module data_mem_responder #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Address   = 8,
    parameter int unsigned Latency   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    input  logic [3:0]           req_wmask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int unsigned Lanes = DataWidth / 8;
    localparam int unsigned Depth = 1 << Address;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 accept, access, rsp_done;

    logic                 we_q;
    logic [31:0]          addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [3:0]           wmask_q;

    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [DataWidth-1:0] acc_wdata;
    logic [3:0]           acc_wmask;
    logic [Address-1:0]   acc_idx;
    logic                 acc_err;

    logic [DataWidth-1:0] mem [Depth];

    // With Latency=0 the access happens on the accept edge itself, so the
    // operands come straight from the request port instead of the capture
    // registers.
    always_comb begin
        acc_we    = (state_q == IDLE) ? req_we    : we_q;
        acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        acc_wmask = (state_q == IDLE) ? req_wmask : wmask_q;
        acc_idx   = acc_addr[Address+1:2];
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:Address+2] != '0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        accept   = 1'b0;
        access   = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ready rises one edge after reset release
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    ready_d = 1'b0;
                    if (Latency == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(Latency - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    rsp_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
            end
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (!acc_err && !acc_we) ? mem[acc_idx] : '0;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Memory is not reset; writes only happen on an access edge, which the
    // FSM can never reach while rst is low.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            for (int unsigned i = 0; i < Lanes; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Three responders with Latency 0, 1 and 7 are driven independently. A
//   transaction-level model (memory array plus per-transaction countdown)
//   predicts every output on every cycle. Directed literal checks pin the
//   model; a random phase exercises all three instances concurrently.
module tb_data_mem_responder;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 7);
    endfunction

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv   [NI];
    logic        rdy  [NI];
    logic        rwe  [NI];
    logic [31:0] raddr[NI];
    logic [31:0] rwd  [NI];
    logic [3:0]  rwm  [NI];
    logic        rspv [NI];
    logic        rspr [NI];
    logic [31:0] rrd  [NI];
    logic        rerr [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .DataWidth(32),
            .Address  (8),
            .Latency  (lat_of(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst_n),
            .req_valid(rv[g]),
            .req_ready(rdy[g]),
            .req_we   (rwe[g]),
            .req_addr (raddr[g]),
            .req_wdata(rwd[g]),
            .req_wmask(rwm[g]),
            .rsp_valid(rspv[g]),
            .rsp_ready(rspr[g]),
            .rsp_rdata(rrd[g]),
            .rsp_err  (rerr[g])
        );
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state
    logic [31:0] m_mem [NI][256];
    bit   [3:0]  m_kb  [NI][256];   // which bytes of each word are known
    bit          m_up  [NI];
    bit          m_ready[NI];
    bit          m_wait[NI];
    int          m_left[NI];
    bit          m_rspv[NI];
    bit          m_err [NI];
    logic [31:0] m_data[NI];
    logic [3:0]  m_km  [NI];
    logic        m_we  [NI];
    logic [31:0] m_addr[NI];
    logic [31:0] m_wd  [NI];
    logic [3:0]  m_wm  [NI];
    bit          mo_acc, mo_err;
    int          mo_idx;
    logic [31:0] cmp_bm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input int hold, input bit compete,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int acyc);
        int b;
        rwe[k] = we; raddr[k] = addr; rwd[k] = wd; rwm[k] = wm;
        rv[k] = 1'b1;
        rspr[k] = (hold == 0);
        b = 0;
        while (rdy[k] !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk($sformatf("acc_ready[%0d]", k), 32'(rdy[k]), 32'd1);
        acyc = cyc;
        @(negedge clk);
        rv[k] = 1'b0;
        rwe[k] = 1'($urandom); raddr[k] = $urandom; rwd[k] = $urandom; rwm[k] = 4'($urandom);
        lat = 1;
        while (rspv[k] !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("rsp_seen[%0d]", k), 32'(rspv[k]), 32'd1);
        rd = rrd[k];
        er = rerr[k];
        for (int i = 0; i < hold; i++) begin
            rv[k] = compete;
            rwe[k] = 1'b1; raddr[k] = 32'h4 * $urandom_range(0, 7);
            @(negedge clk);
            chk($sformatf("hold_valid[%0d]", k), 32'(rspv[k]), 32'd1);
            chk($sformatf("hold_ready[%0d]", k), 32'(rdy[k]), 32'd0);
        end
        rv[k] = 1'b0;
        rspr[k] = 1'b1;
        @(negedge clk);
        rspr[k] = 1'b0;
    endtask

    task automatic rand_run(input int k);
        logic [31:0] rd, addr;
        logic er;
        int lat, ac, r, word;
        repeat (40) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            word = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'(word * 4 + $urandom_range(1, 3));
            else if (r == 1) addr = 32'(word * 4) | (32'h400 << $urandom_range(0, 21));
            else             addr = 32'(word * 4);
            txn(k, 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0,
                rd, er, lat, ac);
            chk($sformatf("rand_lat[%0d]", k), 32'(lat), 32'(lat_of(k) + 1));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, ac1, ac2, b;
        for (int k = 0; k < NI; k++) begin
            rv[k] = 0; rwe[k] = 0; raddr[k] = 0; rwd[k] = 0; rwm[k] = 0; rspr[k] = 0;
            m_km[k] = 4'hF; m_data[k] = '0;
        end

        fork
            // model: advances on each edge and on asynchronous reset
            forever begin
                @(posedge clk or negedge rst_n);
                for (int k = 0; k < NI; k++) begin
                    if (!rst_n) begin
                        m_up[k] = 0; m_ready[k] = 0; m_wait[k] = 0; m_rspv[k] = 0;
                        m_err[k] = 0; m_data[k] = '0; m_km[k] = 4'hF;
                    end else begin
                        mo_acc = 0;
                        if (!m_up[k]) begin
                            m_up[k] = 1; m_ready[k] = 1;
                        end else if (m_ready[k]) begin
                            if (rv[k]) begin
                                m_ready[k] = 0;
                                m_we[k] = rwe[k]; m_addr[k] = raddr[k];
                                m_wd[k] = rwd[k]; m_wm[k] = rwm[k];
                                if (lat_of(k) == 0) mo_acc = 1;
                                else begin m_wait[k] = 1; m_left[k] = lat_of(k); end
                            end
                        end else if (m_wait[k]) begin
                            if (m_left[k] == 1) begin m_wait[k] = 0; mo_acc = 1; end
                            else m_left[k]--;
                        end else if (m_rspv[k] && rspr[k]) begin
                            m_rspv[k] = 0; m_err[k] = 0; m_data[k] = '0; m_km[k] = 4'hF;
                            m_ready[k] = 1;
                        end
                        if (mo_acc) begin
                            mo_err = (m_addr[k] % 4 != 0) || (m_addr[k] >= 32'd1024);
                            mo_idx = int'(m_addr[k] / 4) % 256;
                            m_rspv[k] = 1; m_err[k] = mo_err; m_data[k] = '0; m_km[k] = 4'hF;
                            if (!mo_err && m_we[k]) begin
                                for (int bb = 0; bb < 4; bb++) begin
                                    if (m_wm[k][bb]) begin
                                        m_mem[k][mo_idx][8*bb +: 8] = m_wd[k][8*bb +: 8];
                                        m_kb[k][mo_idx][bb] = 1'b1;
                                    end
                                end
                            end else if (!mo_err) begin
                                m_data[k] = m_mem[k][mo_idx];
                                m_km[k]   = m_kb[k][mo_idx];
                            end
                        end
                    end
                end
            end
            // compare every cycle, away from the active edge
            forever begin
                @(negedge clk);
                for (int k = 0; k < NI; k++) begin
                    cmp_bm = {{8{m_km[k][3]}}, {8{m_km[k][2]}}, {8{m_km[k][1]}}, {8{m_km[k][0]}}};
                    chk($sformatf("req_ready[%0d]", k), 32'(rdy[k]),  32'(m_ready[k]));
                    chk($sformatf("rsp_valid[%0d]", k), 32'(rspv[k]), 32'(m_rspv[k]));
                    chk($sformatf("rsp_err[%0d]", k),   32'(rerr[k]), 32'(m_err[k]));
                    if (cmp_bm != 0)
                        chk($sformatf("rsp_rdata[%0d]", k), rrd[k] & cmp_bm, m_data[k] & cmp_bm);
                end
            end
        join_none

        // Reset for two cycles, then release
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(rdy[k]), 32'd0);
            chk("rst_valid", 32'(rspv[k]), 32'd0);
            chk("rst_rdata", rrd[k], 32'd0);
            chk("rst_err", 32'(rerr[k]), 32'd0);
        end
        rst_n = 1'b1;
        #1 chk("rel_ready_low", 32'(rdy[1]), 32'd0);
        @(posedge clk);
        #1 chk("rel_ready_high", 32'(rdy[1]), 32'd1);
        @(negedge clk);

        // First store, Latency=1
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat, ac1);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", 32'(er), 32'd0);

        // Byte-masked merge
        txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er, lat, ac1);
        txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 1'b0, rd, er, lat, ac1);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac1);
        chk("merge_rdata", rd, 32'h11BB33DD);

        // Misaligned and out-of-range
        txn(1, 1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac1);
        chk("misal_err", 32'(er), 32'd1);
        chk("misal_rdata", rd, 32'd0);
        txn(1, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 0, 1'b0, rd, er, lat, ac1);
        txn(1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, lat, ac1);
        chk("oor_err", 32'(er), 32'd1);
        txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac1);
        chk("oor_untouched", rd, 32'h0BADCAFE);
        chk("oor_load_err", 32'(er), 32'd0);

        // Backpressure with a competing request
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b1, rd, er, lat, ac1);
        chk("bp_rdata", rd, 32'h11BB33DD);
        chk("bp_ready_after", 32'(rdy[1]), 32'd1);

        // Latency sweep and back-to-back throughput
        for (int k = 0; k < NI; k++) begin
            txn(k, 1'b1, 32'h8, 32'h5A5A0000 + 32'(k), 4'hF, 0, 1'b0, rd, er, lat, ac1);
            txn(k, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac1);
            chk($sformatf("sweep_lat[%0d]", k), 32'(lat), (k == 0) ? 32'd1 : ((k == 1) ? 32'd2 : 32'd8));
            chk($sformatf("sweep_rdata[%0d]", k), rd, 32'h5A5A0000 + 32'(k));
            txn(k, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac2);
            chk($sformatf("b2b_period[%0d]", k), 32'(ac2 - ac1), (k == 0) ? 32'd2 : ((k == 1) ? 32'd3 : 32'd9));
        end

        // Reset during WAIT discards the pending store
        txn(2, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 1'b0, rd, er, lat, ac1);
        rwe[2] = 1'b1; raddr[2] = 32'h40; rwd[2] = 32'hCAFEF00D; rwm[2] = 4'hF; rv[2] = 1'b1;
        b = 0;
        while (rdy[2] !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("mid_acc_ready", 32'(rdy[2]), 32'd1);
        @(negedge clk);
        rv[2] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rsp_valid", 32'(rspv[2]), 32'd0);
        @(negedge clk);
        txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, ac1);
        chk("mid_old_value", rd, 32'h12345678);

        // Random traffic on all three instances at once
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
